fabric_config_frame_loader: RTL and testbench
=============================================

// Module: fabric_config_frame_loader
// PURPOSE
//  Loads configuration frames into the fabric's config latch array (LHQD1 rows
//  that drive the MUX4PTv4/MUX16PTv2/cus_mux* selects). Accepts a word stream
//  (valid/ready) of header + frame words. Drives FrameData plus one-hot column
//  and frame strobes using a setup/strobe/hold sequence.
//  Timing rule: latch inputs never change while any latch enable is high.
// PARAMETERS
//  FRAME_BITS     32  width of s_data and FrameData (>= 32)
//  FRAMES_PER_COL 20  strobe lines per column (1..65535)
//  NUM_COLUMNS    8   fabric columns (1..256)
//  STROBE_CYCLES  2   cycles FrameStrobe stays high (>= 1)
// PORTS
//  CLK          in   1               clock
//  RESET        in   1               asynchronous, active-high reset
//  s_data       in   FRAME_BITS      input word
//  s_valid      in   1               s_data valid
//  s_ready      out  1               loader accepts word this cycle
//  FrameData    out  FRAME_BITS      data presented to latch D pins
//  ColSelect    out  NUM_COLUMNS     one-hot column enable
//  FrameStrobe  out  FRAMES_PER_COL  one-hot latch enable (E) within column
//  busy         out  1               high when not in IDLE
//  done         out  1               one-cycle pulse after last frame's HOLD
//  hdr_err      out  1               sticky header error, cleared only by RESET
//  crc_err      out  1               sticky checksum error (0 unless CFG_CRC_EN)
// BEHAVIOUR
//  - Reset (async): state=IDLE. All outputs 0, except s_ready=1.
//    Reset mid-strobe drops FrameStrobe/ColSelect immediately.
//  - Transfer occurs when s_valid & s_ready at CLK rise.
//  - s_ready=1 only in IDLE and WAIT_WORD. Combinational from state, not from s_valid.
//  - Header word: [31:24]=8'hFA sync, [23:16]=column C, [15:0]=frame count N.
//    hdr_err=1, word dropped, stay IDLE if:
//      sync != 8'hFA, or C >= NUM_COLUMNS, or N == 0, or N > FRAMES_PER_COL.
//  - FSM:
//    IDLE -> (valid header) WAIT_WORD, idx=0, latch C and N
//    WAIT_WORD -> (transfer) SETUP; FrameData<=s_data; ColSelect<=1<<C
//    SETUP (1 cyc, strobes low) -> STROBE
//    STROBE: FrameStrobe=1<<idx for STROBE_CYCLES cycles -> HOLD
//    HOLD (1 cyc, strobe low, FrameData held) -> idx==N-1 ? FINISH : WAIT_WORD (idx++)
//    FINISH: done=1 for 1 cycle; ColSelect and FrameData cleared -> IDLE
//  - Per-frame latency from accept: 1 + STROBE_CYCLES + 1 cycles.
//    Fastest frame rate is one word per STROBE_CYCLES+3 cycles.
//  - FrameData and ColSelect are stable from SETUP through HOLD.
//  - FrameStrobe and ColSelect are registered outputs (no glitches).
//  - Only s_valid is sampled in non-accepting states; s_data is ignored there.
//  - Multiple headers back-to-back are allowed. hdr_err does not block later loads.
// CONFIGURATION
//  CFG_CRC_EN defined:
//    - Running XOR of all N frame words (reset per header).
//    - After the last HOLD, state CHECK takes one extra word (s_ready=1).
//    - If that word differs from the running XOR, crc_err=1 (sticky).
//    - Then FINISH. Strobed frames are not rolled back.
//  CFG_CRC_EN undefined:
//    - No trailer word. HOLD of the last frame goes to FINISH.
//    - crc_err tied to 0.
// TESTING
//  1 Reset: after RESET, s_ready=1, busy=0, and all strobes, ColSelect, FrameData and errors are 0.
//  2 Header 32'hFA03_0002, then words 32'hDEADBEEF and 32'h12345678, defaults, s_valid always 1:
//    - ColSelect=8'h08.
//    - FrameStrobe=1 for 2 cycles, then 2 for 2 cycles.
//    - FrameData stable 1 cycle before and after each pulse.
//    - done pulses once. Total 1 + 2*5 + 1 cycles.
//  3 Bad headers each set hdr_err with no strobe activity:
//    32'hFB00_0001, 32'hFA08_0001, 32'hFA00_0000, 32'hFA00_0015.
//    Then valid header 32'hFA00_0001 still loads.
//  4 Backpressure: s_valid low for 7 cycles between frame words.
//    FSM waits in WAIT_WORD with strobes low and FrameData unchanged.
//    Resumes correctly.
//  5 Assert RESET while FrameStrobe=4 (3rd frame of 5).
//    Strobe drops the same cycle, state=IDLE, next header loads normally.
//  6 CFG_CRC_EN defined: header 32'hFA01_0002, words A5A5A5A5 and 0F0F0F0F.
//    Trailer AAAAAAAA -> crc_err=0. Trailer 00000000 -> crc_err=1.
//    done pulses in both cases.

Source files
------------

// File: rtl/fabric_config_frame_loader_if.sv
// Word-stream interface feeding the fabric configuration frame loader.
// The master drives s_data/s_valid; the loader (slave) drives s_ready.
interface fabric_config_frame_loader_if #(
  parameter int FRAME_BITS = 32
);
  logic [FRAME_BITS-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/fabric_config_frame_loader.sv
// Fabric configuration frame loader.
// Takes a header word (8'hFA sync, column, frame count) followed by frame words
// and writes each frame into the config latch array with a
// setup / strobe / hold sequence, so latch D inputs and the column select never
// move while any latch enable is high.
// Optional build macro: CFG_CRC_EN adds a trailer word that must equal the
// XOR of all frame words of the load; a mismatch sets the sticky crc_err.
module fabric_config_frame_loader #(
  parameter int FRAME_BITS     = 32,
  parameter int FRAMES_PER_COL = 20,
  parameter int NUM_COLUMNS    = 8,
  parameter int STROBE_CYCLES  = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  fabric_config_frame_loader_if.slave s_if,
  output logic [FRAME_BITS-1:0]     FrameData,
  output logic [NUM_COLUMNS-1:0]    ColSelect,
  output logic [FRAMES_PER_COL-1:0] FrameStrobe,
  output logic                      busy,
  output logic                      done,
  output logic                      hdr_err,
  output logic                      crc_err
);

  localparam int SCW = $clog2(STROBE_CYCLES + 1);
  localparam logic [8:0]  LP_NCOL = 9'(NUM_COLUMNS);
  localparam logic [16:0] LP_NFRM = 17'(FRAMES_PER_COL);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_CHECK,
    ST_FINISH
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [7:0]                r_col;
  logic [15:0]               r_n;
  logic [15:0]               r_idx;
  logic [SCW-1:0]            r_scnt;
  logic [FRAME_BITS-1:0]     r_frame_data;
  logic [NUM_COLUMNS-1:0]    r_col_sel;
  logic [FRAMES_PER_COL-1:0] r_frame_strobe;
  logic                      r_hdr_err;

  logic       w_ready;
  logic       w_xfer;
  logic       w_hdr_ok;
  logic       w_last_frame;
  logic       w_strobe_last;
  logic [7:0] w_hdr_sync;
  logic [7:0] w_hdr_col;
  logic [15:0] w_hdr_n;

  // Header fields always live in the low 32 bits of the word.
  assign w_hdr_sync = s_if.s_data[31:24];
  assign w_hdr_col  = s_if.s_data[23:16];
  assign w_hdr_n    = s_if.s_data[15:0];
  assign w_hdr_ok   = (w_hdr_sync == 8'hFA) && ({1'b0, w_hdr_col} < LP_NCOL) &&
                      (w_hdr_n != 16'd0) && ({1'b0, w_hdr_n} <= LP_NFRM);

  // Ready depends on state only, never on s_valid.
  assign w_ready       = (r_state == ST_IDLE) || (r_state == ST_WAIT_WORD) ||
                         (r_state == ST_CHECK);
  assign w_xfer        = s_if.s_valid & w_ready;
  assign w_last_frame  = (r_idx == r_n - 16'd1);
  assign w_strobe_last = (r_scnt == SCW'(STROBE_CYCLES - 1));

  assign s_if.s_ready = w_ready;
  assign FrameData    = r_frame_data;
  assign ColSelect    = r_col_sel;
  assign FrameStrobe  = r_frame_strobe;
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_FINISH);
  assign hdr_err      = r_hdr_err;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_xfer && w_hdr_ok) w_next = ST_WAIT_WORD;
      ST_WAIT_WORD: if (w_xfer) w_next = ST_SETUP;
      ST_SETUP:     w_next = ST_STROBE;
      ST_STROBE:    if (w_strobe_last) w_next = ST_HOLD;
      ST_HOLD: begin
        if (!w_last_frame) w_next = ST_WAIT_WORD;
`ifdef CFG_CRC_EN
        else               w_next = ST_CHECK;
`else
        else               w_next = ST_FINISH;
`endif
      end
      ST_CHECK:     if (w_xfer) w_next = ST_FINISH;
      ST_FINISH:    w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Header capture, frame index, strobe timing and the registered latch-side outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_col          <= '0;
      r_n            <= '0;
      r_idx          <= '0;
      r_scnt         <= '0;
      r_frame_data   <= '0;
      r_col_sel      <= '0;
      r_frame_strobe <= '0;
      r_hdr_err      <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_xfer) begin
        if (w_hdr_ok) begin
          r_col <= w_hdr_col;
          r_n   <= w_hdr_n;
          r_idx <= '0;
        end else begin
          r_hdr_err <= 1'b1;
        end
      end

      if ((r_state == ST_WAIT_WORD) && w_xfer) begin
        r_frame_data <= s_if.s_data;
        r_col_sel    <= NUM_COLUMNS'(1) << r_col;
      end

      if ((r_state == ST_HOLD) && !w_last_frame) r_idx <= r_idx + 16'd1;

      if (r_state == ST_STROBE) r_scnt <= r_scnt + SCW'(1);
      else                      r_scnt <= '0;

      // Strobe is a flop driven from the next state, so it is glitch-free and
      // high exactly for the STROBE cycles.
      r_frame_strobe <= (w_next == ST_STROBE) ? (FRAMES_PER_COL'(1) << r_idx) : '0;

      if (w_next == ST_FINISH) begin
        r_frame_data <= '0;
        r_col_sel    <= '0;
      end
    end
  end

`ifdef CFG_CRC_EN
  logic [FRAME_BITS-1:0] r_crc;
  logic                  r_crc_err;

  // Running XOR of the frame words, compared against the trailer word.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_crc     <= '0;
      r_crc_err <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_xfer && w_hdr_ok)   r_crc <= '0;
      else if ((r_state == ST_WAIT_WORD) && w_xfer)     r_crc <= r_crc ^ s_if.s_data;
      if ((r_state == ST_CHECK) && w_xfer && (s_if.s_data != r_crc)) r_crc_err <= 1'b1;
    end
  end

  assign crc_err = r_crc_err;
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_fabric_config_frame_loader.sv
// Self-checking bench for fabric_config_frame_loader (default parameters).
// Frame words are pushed to a scoreboard as they are driven; a negedge monitor
// pops one entry per strobe pulse and checks strobe, column, data, pulse width
// and setup/hold stability. Build with +define+CFG_CRC_EN to exercise the trailer.
module tb_fabric_config_frame_loader;

  localparam int FB  = 32;
  localparam int FPC = 20;
  localparam int NC  = 8;
  localparam int SC  = 2;

  typedef struct packed {
    logic [NC-1:0]  col;
    logic [FPC-1:0] strb;
    logic [FB-1:0]  data;
  } exp_t;

  logic           CLK;
  logic           RESET;
  logic [FB-1:0]  FrameData;
  logic [NC-1:0]  ColSelect;
  logic [FPC-1:0] FrameStrobe;
  logic           busy;
  logic           done;
  logic           hdr_err;
  logic           crc_err;

  fabric_config_frame_loader_if #(.FRAME_BITS(FB)) bus ();

  fabric_config_frame_loader #(
    .FRAME_BITS(FB), .FRAMES_PER_COL(FPC), .NUM_COLUMNS(NC), .STROBE_CYCLES(SC)
  ) dut (
    .CLK(CLK), .RESET(RESET), .s_if(bus),
    .FrameData(FrameData), .ColSelect(ColSelect), .FrameStrobe(FrameStrobe),
    .busy(busy), .done(done), .hdr_err(hdr_err), .crc_err(crc_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  exp_t        sb[$];
  logic [31:0] wq[$];
  int          cyc = 0;
  int          last_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  bit          mon_en = 0;
  logic        crc_exp = 1'b0;

  logic [FPC-1:0] prev_strobe;
  logic [FB-1:0]  prev_data;
  logic [NC-1:0]  prev_col;
  int             run;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Strobe / done monitor.
  always @(negedge CLK) begin
    if (!mon_en || RESET) begin
      prev_strobe = '0;
      run         = 0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (FrameStrobe != '0 && prev_strobe == '0) begin
        check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
        check("setup_data", FrameData, prev_data);
        check("setup_col", ColSelect, prev_col);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_val", FrameStrobe, e.strb);
          check("strobe_col", ColSelect, e.col);
          check("strobe_data", FrameData, e.data);
        end
        run = 1;
      end else if (FrameStrobe != '0) begin
        check("strobe_steady", FrameStrobe, prev_strobe);
        run++;
      end else if (prev_strobe != '0) begin
        check("strobe_width", 64'(run), 64'(SC));
        check("hold_data", FrameData, prev_data);
        check("hold_col", ColSelect, prev_col);
      end
      prev_strobe = FrameStrobe;
    end
    prev_data = FrameData;
    prev_col  = ColSelect;
  end

  // Present one word and hold it until accepted; s_valid drops right after.
  task automatic send(input logic [31:0] w);
    int t = 0;
    @(negedge CLK);
    bus.s_valid = 1'b1;
    bus.s_data  = w;
    while (!bus.s_ready && t < 200) begin
      @(negedge CLK);
      t++;
    end
    check("ready_wait", bus.s_ready, 1'b1);
    @(posedge CLK);
    #1;
    last_cyc    = cyc;
    bus.s_valid = 1'b0;
  endtask

  // Full load of the words in wq into column col; gap = idle cycles after word 0.
  task automatic load(input logic [7:0] col, input int gap, input logic [31:0] crc_flip);
    logic [31:0] x = '0;
    int d0, hc, t, total;
    d0 = done_cnt;
    send({8'hFA, col, 16'(wq.size())});
    hc = last_cyc;
    foreach (wq[i]) begin
      sb.push_back('{col: NC'(1) << col, strb: FPC'(1) << i, data: wq[i]});
      x = x ^ wq[i];
      send(wq[i]);
      if (i == 0 && gap > 0) begin
        repeat (gap) @(negedge CLK);
        check("bp_ready", bus.s_ready, 1'b1);
        check("bp_strobe", FrameStrobe, '0);
        check("bp_data", FrameData, wq[0]);
        check("bp_col", ColSelect, NC'(1) << col);
      end
    end
    total = 2 + wq.size() * (SC + 3);
`ifdef CFG_CRC_EN
    if (crc_flip != '0) crc_exp = 1'b1;
    send(x ^ crc_flip);
    total = total + 1;
`endif
    t = 0;
    while (done_cnt == d0 && t < 500) begin
      @(negedge CLK);
      t++;
    end
    if (gap == 0) check("load_cycles", 64'(done_cyc - hc + 2), 64'(total));
    repeat (2) @(negedge CLK);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("end_busy", busy, 1'b0);
    check("end_col", ColSelect, '0);
    check("end_data", FrameData, '0);
    check("end_sb_empty", 64'(sb.size()), 64'd0);
    check("crc_err", crc_err, crc_exp);
  endtask

  logic [31:0] bad[4];

  initial begin
    RESET       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bad[0] = 32'hFB00_0001;
    bad[1] = 32'hFA08_0001;
    bad[2] = 32'hFA00_0000;
    bad[3] = 32'hFA00_0015;

    // 1: reset state
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_ready", bus.s_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_strobe", FrameStrobe, '0);
    check("rst_col", ColSelect, '0);
    check("rst_data", FrameData, '0);
    check("rst_hdr_err", hdr_err, 1'b0);
    check("rst_crc_err", crc_err, 1'b0);
    check("rst_done", done, 1'b0);
    mon_en = 1;

    // 2: two frames into column 3
    wq.delete();
    wq.push_back(32'hDEADBEEF);
    wq.push_back(32'h12345678);
    load(8'd3, 0, '0);
    check("t2_hdr_err", hdr_err, 1'b0);

    // 3: malformed headers are dropped and flagged
    foreach (bad[i]) begin
      send(bad[i]);
      @(negedge CLK);
      check("bad_hdr_err", hdr_err, 1'b1);
      check("bad_busy", busy, 1'b0);
      check("bad_strobe", FrameStrobe, '0);
    end
    wq.delete();
    wq.push_back(32'hCAFEF00D);
    load(8'd0, 0, '0);
    check("t3_hdr_sticky", hdr_err, 1'b1);

    // 4: backpressure between frame words
    wq.delete();
    wq.push_back(32'h1111_2222);
    wq.push_back(32'h3333_4444);
    wq.push_back(32'h5555_6666);
    load(8'd2, 7, '0);

    // 5: reset in the middle of the third strobe of five
    send(32'hFA01_0005);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] w;
      w = 32'hA000_0000 + 32'(i);
      sb.push_back('{col: NC'(1) << 1, strb: FPC'(1) << i, data: w});
      send(w);
    end
    begin
      int t = 0;
      while (FrameStrobe != FPC'(4) && t < 50) begin
        @(negedge CLK);
        t++;
      end
    end
    check("t5_strobe_seen", FrameStrobe, FPC'(4));
    mon_en = 0;
    #1 RESET = 1'b1;
    #1;
    check("t5_strobe_drop", FrameStrobe, '0);
    check("t5_col_drop", ColSelect, '0);
    check("t5_busy", busy, 1'b0);
    check("t5_ready", bus.s_ready, 1'b1);
    check("t5_hdr_err", hdr_err, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    sb.delete();
    crc_exp = 1'b0;
    mon_en  = 1;
    wq.delete();
    wq.push_back(32'h0BAD_F00D);
    load(8'd4, 0, '0);

`ifdef CFG_CRC_EN
    // 6: trailer checksum good, then bad
    wq.delete();
    wq.push_back(32'hA5A5A5A5);
    wq.push_back(32'h0F0F0F0F);
    load(8'd1, 0, '0);
    load(8'd1, 0, 32'hAAAAAAAA);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
